solar_adc_scan: RTL and testbench

Scan sequencer that shares one 8-bit ADC among the four light sensors (north, east, south, west) of the solar tracker. It periodically converts each channel 2^AVG_LOG2 times and averages the samples. It then presents all four averaged values to the tracker's direction logic, updating them atomically. It sits between the single ADC front-end and the threshold-compare/motor FSM.

---
 rtl/solar_adc_scan.sv | 153 +++++++++++++++
 tb/tb_solar_adc_scan.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solar_adc_scan.sv
`default_nettype none
// ============================================================================
// Module   : solar_adc_scan
// Brief    : Shares one 8-bit ADC across four light sensors, averages
//            2^AVG_LOG2 samples per channel and publishes all four at once.
// Revision : 1.0
// ============================================================================
module solar_adc_scan #(
    parameter int SCAN_PERIOD = 1000,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       adc_start,
    output logic [1:0] adc_ch,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic [7:0] lsn,
    output logic [7:0] lse,
    output logic [7:0] lss,
    output logic [7:0] lsw,
    output logic       scan_valid,
    output logic       adc_err
);

    localparam int c_acc_w = 8 + AVG_LOG2;
    localparam int c_ps_w  = $clog2(SCAN_PERIOD);
    localparam int c_to_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_smp_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [c_ps_w-1:0]  c_ps_last  = c_ps_w'(SCAN_PERIOD - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT - 1);
    localparam logic [c_smp_w-1:0] c_smp_last = c_smp_w'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_ps_w-1:0]    r_ps;
    logic [c_to_w-1:0]    r_to;
    logic [c_smp_w-1:0]   r_smp;
    logic [1:0]           r_ch;
    logic [c_acc_w-1:0]   r_acc [4];
    logic [7:0]           r_ls  [4];
    logic                 r_adc_start;
    logic                 r_scan_valid;
    logic                 r_adc_err;
    logic                 w_tick;

    assign w_tick = en && (r_ps == c_ps_last);

    // Prescaler parks at zero while disabled so re-enabling gives a full period
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_ps <= '0;
        end else if (r_ps == c_ps_last) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + c_ps_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_to         <= '0;
            r_smp        <= '0;
            r_ch         <= '0;
            r_adc_start  <= 1'b0;
            r_scan_valid <= 1'b0;
            r_adc_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
                r_ls[i]  <= '0;
            end
        end else begin
            r_adc_start  <= 1'b0;
            r_scan_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_ch        <= '0;
                        r_smp       <= '0;
                        r_adc_start <= 1'b1;
                        r_state     <= S_START;
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end
                S_START: begin
                    r_to    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done in the final allowed cycle wins over the timeout
                    if (adc_done) begin
                        r_acc[r_ch] <= r_acc[r_ch] + c_acc_w'(adc_data);
                        if (r_smp != c_smp_last) begin
                            r_smp       <= r_smp + c_smp_w'(1);
                            r_adc_start <= 1'b1;
                            r_state     <= S_START;
                        end else if (r_ch != 2'd3) begin
                            r_smp       <= '0;
                            r_ch        <= r_ch + 2'd1;
                            r_adc_start <= 1'b1;
                            r_state     <= S_START;
                        end else begin
                            r_state <= S_COMMIT;
                        end
                    end else if (r_to == c_to_last) begin
                        r_adc_err <= 1'b1;
                        r_state   <= S_IDLE;
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= '0;
                        end
                    end else begin
                        r_to <= r_to + c_to_w'(1);
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < 4; i++) begin
                        r_ls[i]  <= r_acc[i][c_acc_w-1:AVG_LOG2];
                        r_acc[i] <= '0;
                    end
                    r_adc_err    <= 1'b0;
                    r_scan_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_start  = r_adc_start;
    assign adc_ch     = r_ch;
    assign lsn        = r_ls[0];
    assign lse        = r_ls[1];
    assign lss        = r_ls[2];
    assign lsw        = r_ls[3];
    assign scan_valid = r_scan_valid;
    assign adc_err    = r_adc_err;

endmodule
`default_nettype wire

// File: tb/tb_solar_adc_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_solar_adc_scan
// Brief    : Self-checking bench for solar_adc_scan with a reactive ADC model.
// Revision : 1.0
// ============================================================================
module tb_solar_adc_scan;

    localparam int SP  = 200;
    localparam int SP2 = 50;
    localparam int AL  = 2;
    localparam int TO  = 8;

    logic       clk;
    logic       rst, en, adc_start, adc_done, scan_valid, adc_err;
    logic [1:0] adc_ch;
    logic [7:0] adc_data, lsn, lse, lss, lsw;

    logic       rst2, en2, adc_start2, adc_done2, scan_valid2, adc_err2;
    logic [1:0] adc_ch2;
    logic [7:0] adc_data2, lsn2, lse2, lss2, lsw2;

    solar_adc_scan #(.SCAN_PERIOD(SP), .AVG_LOG2(AL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en),
        .adc_start(adc_start), .adc_ch(adc_ch),
        .adc_done(adc_done), .adc_data(adc_data),
        .lsn(lsn), .lse(lse), .lss(lss), .lsw(lsw),
        .scan_valid(scan_valid), .adc_err(adc_err)
    );

    // Second instance with a period shorter than a scan, so ticks get dropped
    solar_adc_scan #(.SCAN_PERIOD(SP2), .AVG_LOG2(AL), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst(rst2), .en(en2),
        .adc_start(adc_start2), .adc_ch(adc_ch2),
        .adc_done(adc_done2), .adc_data(adc_data2),
        .lsn(lsn2), .lse(lse2), .lss(lss2), .lsw(lsw2),
        .scan_valid(scan_valid2), .adc_err(adc_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc, cyc2;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (rst2) cyc2 <= 0;
        else      cyc2 <= cyc2 + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [15:0][7:0] smp;
        logic [3:0][7:0]  ls;
        int               lat;
    } vec_t;

    typedef struct packed {
        logic [3:0][7:0] ls;
        int              span;
    } exp_t;

    vec_t vecs [4];
    exp_t exp_q [$];
    int   exp2_q [$];

    task automatic set_ch(input int v, input int ch, input int a, input int b,
                          input int c, input int d, input int avg);
        vecs[v].smp[ch*4+0] = 8'(a);
        vecs[v].smp[ch*4+1] = 8'(b);
        vecs[v].smp[ch*4+2] = 8'(c);
        vecs[v].smp[ch*4+3] = 8'(d);
        vecs[v].ls[ch]      = 8'(avg);
    endtask

    // ADC model state
    logic [15:0][7:0] tbl;
    logic [7:0]       resp_data;
    int  lat      = 3;
    int  drop_req = -1;
    int  drop_t   = -1;
    int  req_n    = 0;
    int  wait_cnt = 0;
    int  scan_t0  = -1;
    bit  stray_en = 1'b0;
    bit  err_q    = 1'b0;
    int  sv_cnt   = 0;

    initial begin
        adc_done = 1'b0;
        adc_data = 8'h00;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            adc_data = 8'hFF;
            if (rst) begin
                wait_cnt = 0;
                req_n    = 0;
            end else begin
                if (scan_valid || (adc_err && !err_q)) req_n = 0;
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        adc_done = 1'b1;
                        adc_data = resp_data;
                    end
                end else if (stray_en && (cyc % 3 == 0)) begin
                    adc_done = 1'b1;
                    adc_data = 8'hFF;
                end
                if (adc_start) begin
                    if (req_n == 0) scan_t0 = cyc;
                    check("request count within scan", int'(req_n < 16), 1);
                    check("adc_ch order", int'(adc_ch), req_n / 4);
                    if (req_n == drop_req) begin
                        drop_t = cyc;
                    end else if (req_n < 16) begin
                        wait_cnt  = lat;
                        resp_data = tbl[req_n];
                    end
                    req_n++;
                end
            end
            err_q = adc_err;
        end
    end

    // Scoreboard: pop one expected record per scan_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scan_valid) begin
                sv_cnt++;
                check("scoreboard non-empty at scan_valid", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("lsn", int'(lsn), int'(e.ls[0]));
                    check("lse", int'(lse), int'(e.ls[1]));
                    check("lss", int'(lss), int'(e.ls[2]));
                    check("lsw", int'(lsw), int'(e.ls[3]));
                    check("adc_err at scan_valid", int'(adc_err), 0);
                    check("scan_valid latency from first adc_start", cyc - scan_t0, e.span);
                end
            end
        end
    end

    // Second instance: fixed-latency ADC returning 40, checks no overlap and tick drops
    int w2 = 0, starts2 = 0, sv2_seen = 0;
    initial begin
        adc_done2 = 1'b0;
        adc_data2 = 8'h00;
        forever begin
            @(negedge clk);
            adc_done2 = 1'b0;
            adc_data2 = 8'hFF;
            if (!rst2) begin
                if (w2 > 0) begin
                    w2--;
                    if (w2 == 0) begin
                        adc_done2 = 1'b1;
                        adc_data2 = 8'd40;
                    end
                end
                if (adc_start2) begin
                    check("dut2 request while one outstanding", w2, 0);
                    w2 = 3;
                    starts2++;
                end
                if (cyc2 == 330) check("dut2 requests by cycle 330", starts2, 48);
                if (scan_valid2) begin
                    sv2_seen++;
                    if (exp2_q.size() > 0) begin
                        check("dut2 scan_valid cycle", cyc2, exp2_q.pop_front());
                        check("dut2 lsn", int'(lsn2), 40);
                        check("dut2 lsw", int'(lsw2), 40);
                    end
                end
            end
        end
    end

    task automatic load_vec(input int v);
        tbl = vecs[v].smp;
        lat = vecs[v].lat;
    endtask

    task automatic push_vec(input int v);
        exp_t e;
        e.ls   = vecs[v].ls;
        e.span = 16 * (vecs[v].lat + 1) + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_sv(input int n0, input int budget);
        int k = 0;
        while (sv_cnt == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("scan_valid within budget", int'(sv_cnt != n0), 1);
    endtask

    task automatic check_ls(input string tag, input int v);
        check({tag, " lsn"}, int'(lsn), int'(vecs[v].ls[0]));
        check({tag, " lse"}, int'(lse), int'(vecs[v].ls[1]));
        check({tag, " lss"}, int'(lss), int'(vecs[v].ls[2]));
        check({tag, " lsw"}, int'(lsw), int'(vecs[v].ls[3]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts, nz, n0, k;

        set_ch(0, 0, 10, 11, 12, 13, 11);
        set_ch(0, 1, 200, 200, 200, 200, 200);
        set_ch(0, 2, 0, 0, 0, 3, 0);
        set_ch(0, 3, 255, 255, 255, 255, 255);
        vecs[0].lat = 3;
        set_ch(1, 0, 1, 2, 3, 4, 2);
        set_ch(1, 1, 100, 101, 102, 103, 101);
        set_ch(1, 2, 7, 7, 7, 7, 7);
        set_ch(1, 3, 0, 255, 0, 255, 127);
        vecs[1].lat = 1;
        set_ch(2, 0, 255, 254, 253, 252, 253);
        set_ch(2, 1, 3, 3, 3, 2, 2);
        set_ch(2, 2, 128, 128, 128, 128, 128);
        set_ch(2, 3, 50, 60, 70, 80, 65);
        vecs[2].lat = TO;
        set_ch(3, 0, 0, 0, 0, 0, 0);
        set_ch(3, 1, 9, 9, 9, 9, 9);
        set_ch(3, 2, 250, 251, 252, 253, 251);
        set_ch(3, 3, 1, 1, 1, 0, 0);
        vecs[3].lat = 5;

        rst  = 1'b1;
        en   = 1'b0;
        rst2 = 1'b1;
        en2  = 1'b1;
        tbl  = '0;
        repeat (2) @(negedge clk);
        check("reset adc_start", int'(adc_start), 0);
        check("reset adc_ch", int'(adc_ch), 0);
        check("reset lsn", int'(lsn), 0);
        check("reset lse", int'(lse), 0);
        check("reset lss", int'(lss), 0);
        check("reset lsw", int'(lsw), 0);
        check("reset scan_valid", int'(scan_valid), 0);
        check("reset adc_err", int'(adc_err), 0);
        rst  = 1'b0;
        rst2 = 1'b0;
        exp2_q.push_back(115);
        exp2_q.push_back(215);
        exp2_q.push_back(315);

        starts = 0;
        nz     = 0;
        repeat (2000) begin
            @(negedge clk);
            starts += int'(adc_start);
            if ({lsn, lse, lss, lsw, adc_ch, scan_valid, adc_err} != '0) nz++;
        end
        check("idle adc_start count with en=0", starts, 0);
        check("idle cycles with nonzero outputs", nz, 0);

        // Restart from reset with en high so tick timing is anchored at cycle 0
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            push_vec(v);
            n0 = sv_cnt;
            wait_sv(n0, 400);
            if (v == 0) check("first adc_start cycle", scan_t0, SP);
        end

        // Timeout: the sixth request (E, sample 1) is never answered
        load_vec(0);
        drop_req = 5;
        n0 = sv_cnt;
        k  = 0;
        while (drop_t < 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("dropped request observed", int'(drop_t >= 0), 1);
        while (cyc < drop_t + TO && k < 800) begin
            @(negedge clk);
            k++;
        end
        check("adc_err still 0 at t+TIMEOUT", int'(adc_err), 0);
        @(negedge clk);
        check("adc_err set at t+TIMEOUT+1", int'(adc_err), 1);
        drop_req = -1;
        repeat (40) @(negedge clk);
        check("adc_err sticky after abort", int'(adc_err), 1);
        check("no scan_valid on abort", sv_cnt, n0);
        check_ls("kept after abort", 3);
        push_vec(0);
        wait_sv(n0, 400);

        // Stray adc_done pulses while idle must not leak into the averages
        en       = 1'b0;
        stray_en = 1'b1;
        repeat (30) @(negedge clk);
        stray_en = 1'b0;
        check_ls("unchanged after strays", 0);
        load_vec(1);
        push_vec(1);
        n0 = sv_cnt;
        en = 1'b1;
        wait_sv(n0, 400);

        // Reset during channel S, then a clean restart from channel N
        load_vec(2);
        push_vec(2);
        n0 = sv_cnt;
        k  = 0;
        while (req_n < 10 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("reached channel S before reset", int'(req_n >= 10), 1);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid-scan reset adc_start", int'(adc_start), 0);
        check("mid-scan reset adc_ch", int'(adc_ch), 0);
        check("mid-scan reset lsn", int'(lsn), 0);
        check("mid-scan reset lse", int'(lse), 0);
        check("mid-scan reset lss", int'(lss), 0);
        check("mid-scan reset lsw", int'(lsw), 0);
        check("mid-scan reset scan_valid", int'(scan_valid), 0);
        check("mid-scan reset adc_err", int'(adc_err), 0);
        rst = 1'b0;
        wait_sv(n0, 600);
        check("restart first adc_start cycle", scan_t0, SP);
        check("dut2 scans completed", int'(sv2_seen >= 3), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
